// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// rr_pick() does the round-robin search used at arbitration time.
// The arbiter grants at most MAX_N producers.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int MAX_N = 8;
   localparam int IDX_W = 3;

   // Default beat counter width.
   // It is sized so the counter reaches MAX_BURST-1 without wrapping.
   localparam int DEFAULT_MAX_BURST = 4;
   localparam int BEAT_CNT_W = $clog2(DEFAULT_MAX_BURST) + 1;

   function automatic int beat_cnt_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

   // Returns the first set request after last_owner, wrapping around.
   // The loop walks from the farthest candidate down to the nearest one,
   // so the nearest set request is written last and therefore wins.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                input logic [IDX_W-1:0] last_owner,
                                                input int n);
      logic [IDX_W-1:0] pick;
      int               idx;
      pick = last_owner;
      for (int k = n; k >= 1; k--) begin
         idx = (int'(last_owner) + k) % n;
         if (req[idx]) begin
            pick = IDX_W'(idx);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational owner selection for the FIFO write arbiter.
// Optional feature: FIFO_WR_ARB_PRIO0_EN gives requester 0 absolute priority.
// When that feature is enabled, the other requesters rotate among themselves.
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int OW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [OW-1:0] last_owner,
   output logic [OW-1:0] owner
);

   logic [MAX_N-1:0] req_ext;

   // Widen the request vector to the width used by the package search helper.
   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
   end

   // Pick the next owner.
   // The result is only meaningful while some request is set.
   always_comb begin
`ifdef FIFO_WR_ARB_PRIO0_EN
      if (req[0]) begin
         owner = '0;
      end else begin
         owner = OW'(rr_pick(req_ext & ~MAX_N'(1), IDX_W'(last_owner), N));
      end
`else
      owner = OW'(rr_pick(req_ext, IDX_W'(last_owner), N));
`endif
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among N producers.
// A grant lasts for up to MAX_BURST accepted beats.
// Every grant is followed by one IDLE cycle.
// Optional feature macro: FIFO_WR_ARB_PRIO0_EN (requester 0 always wins arbitration).
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic [N*DW-1:0] req_data,
   input  logic            fifo_full,
   output logic [N-1:0]    grant,
   output logic [N-1:0]    ack,
   output logic            fifo_w_en,
   output logic [DW-1:0]   fifo_data,
   output logic            busy
);

   localparam int OW = $clog2(N);
   localparam int CW = beat_cnt_width(MAX_BURST);

   arb_state_t    state;
   logic [OW-1:0] owner;
   logic [OW-1:0] last_owner;
   logic [OW-1:0] pick;
   logic [CW-1:0] beat_cnt;
   logic          owner_req;
   logic          transfer;
   logic          last_beat;

   rr_priority_pick #(.N(N), .OW(OW)) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .owner      (pick)
   );

   assign owner_req = req[owner];
   assign transfer  = (state == GRANT) && owner_req && !fifo_full;
   assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));

   // Drive the FIFO write side combinationally from the current owner.
   // grant is already one-hot on the owner, so it doubles as the ack mask.
   always_comb begin
      ack       = transfer ? grant : '0;
      fifo_w_en = transfer;
      fifo_data = (state == GRANT) ? req_data[int'(owner)*DW +: DW] : '0;
   end

   // Arbitration and burst-length state machine.
   // All outputs of this block are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         busy       <= 1'b0;
         beat_cnt   <= '0;
         owner      <= '0;
         last_owner <= OW'(N - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state    <= GRANT;
                  owner    <= pick;
                  grant    <= N'(1) << pick;
                  busy     <= 1'b1;
                  beat_cnt <= '0;
               end
            end
            GRANT: begin
               if (!owner_req || (transfer && last_beat)) begin
                  state    <= IDLE;
                  grant    <= '0;
                  busy     <= 1'b0;
                  beat_cnt <= '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
                  // Requester 0 bypasses the rotation.
                  // Leaving last_owner alone keeps the other requesters' turn order.
                  if (owner != '0) begin
                     last_owner <= owner;
                  end
`else
                  last_owner <= owner;
`endif
               end else if (transfer) begin
                  beat_cnt <= beat_cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter.
// A behavioural owner/beat model is checked against the DUT on every falling edge.
// Directed scenarios add literal checks, and a randomized run finishes the test.
// Define FIFO_WR_ARB_PRIO0_EN to exercise the priority-0 build.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            fifo_full = 1'b0;
   logic [N-1:0]    grant;
   logic [N-1:0]    ack;
   logic            fifo_w_en;
   logic [DW-1:0]   fifo_data;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   int sent [N];
   int m_owner = -1;
   int m_beats = 0;
   int m_last  = N - 1;

   logic [DW-1:0] wr_data_q [$];
   int            wr_owner_q [$];

   fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .fifo_full (fifo_full),
      .grant     (grant),
      .ack       (ack),
      .fifo_w_en (fifo_w_en),
      .fifo_data (fifo_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Next owner: the first set request after the previous owner, wrapping around.
   function automatic int modelPick(input logic [N-1:0] r);
`ifdef FIFO_WR_ARB_PRIO0_EN
      if (r[0]) return 0;
`endif
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (m_last + k) % N;
`ifdef FIFO_WR_ARB_PRIO0_EN
         if (idx == 0) continue;
`endif
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   // Drive one cycle of inputs shortly after the rising edge.
   // The data a producer presents is its base value plus the beats already accepted.
   task automatic applyStimulus(input logic [N-1:0] r, input logic f, input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #2;
         req       = r;
         fifo_full = f;
         for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = 8'h11 + 8'(16 * i) + 8'(sent[i]);
         end
      end
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      req       = '0;
      fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      wr_data_q.delete();
      wr_owner_q.delete();
   endtask

   // Compare the DUT with the behavioural model on every falling edge.
   // Afterwards, log accepted writes and advance the model past the next rising edge.
   always @(negedge clk) begin
      logic [N-1:0]  e_grant;
      logic [N-1:0]  e_ack;
      logic          e_xfer;
      logic [DW-1:0] e_data;
      if (!rst_n) begin
         m_owner = -1;
         m_beats = 0;
         m_last  = N - 1;
         checkOutput("rst_grant", 32'(grant), 0);
         checkOutput("rst_busy", 32'(busy), 0);
         checkOutput("rst_ack", 32'(ack), 0);
         checkOutput("rst_wen", 32'(fifo_w_en), 0);
         checkOutput("rst_data", 32'(fifo_data), 0);
      end else begin
         e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
         e_xfer  = (m_owner >= 0) && req[m_owner] && !fifo_full;
         e_ack   = e_xfer ? e_grant : '0;
         e_data  = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
         checkOutput("grant", 32'(grant), 32'(e_grant));
         checkOutput("busy", 32'(busy), 32'(m_owner >= 0));
         checkOutput("ack", 32'(ack), 32'(e_ack));
         checkOutput("wen", 32'(fifo_w_en), 32'(e_xfer));
         checkOutput("data", 32'(fifo_data), 32'(e_data));
         checkOutput("wen_while_full", 32'(fifo_w_en & fifo_full), 0);
         if (fifo_w_en) begin
            wr_data_q.push_back(fifo_data);
            for (int i = 0; i < N; i++) begin
               if (ack[i]) wr_owner_q.push_back(i);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (ack[i]) sent[i]++;
         end
         if (m_owner < 0) begin
            m_owner = modelPick(req);
            m_beats = 0;
         end else if (!req[m_owner]) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
            if (m_owner != 0) m_last = m_owner;
`else
            m_last = m_owner;
`endif
            m_owner = -1;
         end else if (!fifo_full) begin
            m_beats++;
            if (m_beats == MB) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
               if (m_owner != 0) m_last = m_owner;
`else
               m_last = m_owner;
`endif
               m_owner = -1;
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) sent[i] = 0;

      // Single producer: a four-beat burst with data 11..14.
      doReset();
      applyStimulus(4'b0001, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t1_grant_latency", 32'(grant), 0);
      applyStimulus(4'b0001, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t1_grant", 32'(grant), 32'h1);
      checkOutput("t1_busy", 32'(busy), 1);
      applyStimulus(4'b0001, 1'b0, 4);
      @(negedge clk); #1;
      checkOutput("t1_release_grant", 32'(grant), 0);
      checkOutput("t1_release_wen", 32'(fifo_w_en), 0);
      applyStimulus(4'b0000, 1'b0, 2);
      checkOutput("t1_nwrites", 32'(wr_data_q.size()), 4);
      for (int k = 0; k < 4 && k < wr_data_q.size(); k++) begin
         checkOutput("t1_wdata", 32'(wr_data_q[k]), 32'(8'h11 + k));
      end

      // All four requesting: rotation 0,1,2,3,0 with four beats per grant.
      doReset();
      applyStimulus(4'b1111, 1'b0, 27);
      checkOutput("t2_enough_writes", 32'(wr_owner_q.size() >= 20), 1);
      for (int k = 0; k < 20 && k < wr_owner_q.size(); k++) begin
`ifdef FIFO_WR_ARB_PRIO0_EN
         checkOutput("t2_owner", 32'(wr_owner_q[k]), 0);
`else
         checkOutput("t2_owner", 32'(wr_owner_q[k]), 32'((k / 4) % 4));
`endif
      end

      // Owner 2 stalls on full for five cycles after two beats.
      doReset();
      applyStimulus(4'b0100, 1'b0, 3);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0100, 1'b1, 1);
         @(negedge clk); #1;
         checkOutput("t3_hold_grant", 32'(grant), 32'h4);
         checkOutput("t3_hold_ack", 32'(ack), 0);
         checkOutput("t3_hold_wen", 32'(fifo_w_en), 0);
      end
      applyStimulus(4'b0100, 1'b0, 2);
      applyStimulus(4'b0000, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t3_released", 32'(grant), 0);
      applyStimulus(4'b0000, 1'b0, 1);
      checkOutput("t3_nwrites", 32'(wr_owner_q.size()), 4);

      // Owner 1 drops its request after one beat while requester 3 is waiting.
      doReset();
      applyStimulus(4'b1010, 1'b0, 2);
      applyStimulus(4'b1000, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t4_drop_grant", 32'(grant), 32'h2);
      checkOutput("t4_drop_wen", 32'(fifo_w_en), 0);
      applyStimulus(4'b1000, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t4_bubble", 32'(grant), 0);
      applyStimulus(4'b1000, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t4_next_grant", 32'(grant), 32'h8);
      applyStimulus(4'b0000, 1'b0, 3);

      // Asynchronous reset during beat three; arbitration restarts at requester 0.
      doReset();
      applyStimulus(4'b0001, 1'b0, 4);
      #1;
      rst_n = 1'b0;
      req   = '0;
      #1;
      checkOutput("t5_async_grant", 32'(grant), 0);
      checkOutput("t5_async_busy", 32'(busy), 0);
      checkOutput("t5_async_wen", 32'(fifo_w_en), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      applyStimulus(4'b0011, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t5_idle", 32'(grant), 0);
      applyStimulus(4'b0011, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("t5_restart", 32'(grant), 32'h1);
      applyStimulus(4'b0000, 1'b0, 3);

`ifdef FIFO_WR_ARB_PRIO0_EN
      // Requester 0 rises mid-burst: owner 1 finishes, then 0, then rotation resumes at 2.
      doReset();
      applyStimulus(4'b1110, 1'b0, 2);
      @(negedge clk); #1;
      checkOutput("p_grant1", 32'(grant), 32'h2);
      applyStimulus(4'b1111, 1'b0, 4);
      @(negedge clk); #1;
      checkOutput("p_bubble", 32'(grant), 0);
      applyStimulus(4'b1111, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("p_grant0", 32'(grant), 32'h1);
      applyStimulus(4'b1110, 1'b0, 2);
      applyStimulus(4'b1110, 1'b0, 1);
      @(negedge clk); #1;
      checkOutput("p_grant2", 32'(grant), 32'h4);
      applyStimulus(4'b0000, 1'b0, 3);
`endif

      // Randomized requests and full flag, checked by the model every cycle.
      doReset();
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(N'($urandom), ($urandom_range(0, 3) == 0), 1);
      end
      applyStimulus(4'b0000, 1'b0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
